// File: rtl/fertiliser_zone_controller.sv
// Multi-zone fertiliser dosing controller sharing one tank and one flush line.
// A push edge in IDLE doses the selected zone for at most DOSE_CYCLES cycles.
// A fixed FLUSH_CYCLES cleaning flush follows, then the controller returns to IDLE.
// Refused, aborted and out-of-range requests latch a coded alarm.
module fertiliser_zone_controller #(
  parameter int ZONES        = 4,
  parameter int DOSE_CYCLES  = 8,
  parameter int FLUSH_CYCLES = 4,
  localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1,
  localparam int CW = $clog2(((DOSE_CYCLES > FLUSH_CYCLES) ? DOSE_CYCLES : FLUSH_CYCLES) + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             low_level,
  input  logic             empty_tank,
  input  logic [ZONES-1:0] splinker,
  input  logic             fertilise_push,
  input  logic [ZW-1:0]    zone_select,
  input  logic             alarm_clear,
  output logic             fertilising,
  output logic             cleaning,
  output logic [ZONES-1:0] zone_valve,
  output logic             busy,
  output logic             done,
  output logic             alarm,
  output logic [1:0]       alarm_code,
  output logic [CW-1:0]    dose_remaining
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FERTILISE = 2'd1,
    FLUSH     = 2'd2
  } state_t;

  localparam logic [1:0] CODE_REFUSED  = 2'd1;
  localparam logic [1:0] CODE_ABORTED  = 2'd2;
  localparam logic [1:0] CODE_BAD_ZONE = 2'd3;

  state_t         state, state_next;
  logic [CW-1:0]  count, count_next;
  logic [ZW-1:0]  zone, zone_next;
  logic           push_q;
  logic           push_edge;
  logic           alarm_next;
  logic [1:0]     code_next;
  logic           done_next;

  assign push_edge = fertilise_push & ~push_q;

  // State, counter, latched zone, push history, alarm and done pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      zone       <= '0;
      push_q     <= 1'b0;
      alarm      <= 1'b0;
      alarm_code <= 2'd0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      zone       <= zone_next;
      push_q     <= fertilise_push;
      alarm      <= alarm_next;
      alarm_code <= code_next;
      done       <= done_next;
    end
  end

  // Next-state, counter and alarm logic; an alarm event overrides a clear in the same cycle.
  always_comb begin
    state_next = state;
    count_next = count;
    zone_next  = zone;
    alarm_next = alarm;
    code_next  = alarm_code;
    done_next  = 1'b0;
    if (alarm_clear) begin
      alarm_next = 1'b0;
      code_next  = 2'd0;
    end
    case (state)
      IDLE: begin
        if (push_edge) begin
          if (int'(zone_select) >= ZONES) begin
            alarm_next = 1'b1;
            code_next  = CODE_BAD_ZONE;
          end else if (low_level || !splinker[zone_select]) begin
            alarm_next = 1'b1;
            code_next  = CODE_REFUSED;
          end else begin
            zone_next  = zone_select;
            state_next = FERTILISE;
            count_next = CW'(DOSE_CYCLES);
          end
        end
      end
      FERTILISE: begin
        // Losing water or the zone's sprinkler aborts, even on the last dose cycle.
        if (low_level || !splinker[zone]) begin
          alarm_next = 1'b1;
          code_next  = CODE_ABORTED;
          state_next = FLUSH;
          count_next = CW'(FLUSH_CYCLES);
        end else if (empty_tank || count <= CW'(1)) begin
          state_next = FLUSH;
          count_next = CW'(FLUSH_CYCLES);
        end else begin
          count_next = count - CW'(1);
        end
      end
      FLUSH: begin
        // The flush always runs to completion; no input can shorten it.
        if (count <= CW'(1)) begin
          state_next = IDLE;
          count_next = '0;
          done_next  = 1'b1;
        end else begin
          count_next = count - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    fertilising    = (state == FERTILISE);
    cleaning       = (state == FLUSH);
    busy           = (state != IDLE);
    dose_remaining = (state == FERTILISE) ? count : '0;
  end

  // One-hot valve drive for the latched zone while dosing.
  for (genvar gi = 0; gi < ZONES; gi++) begin : g_valve
    assign zone_valve[gi] = (state == FERTILISE) && (zone == ZW'(gi));
  end

endmodule

// File: tb/tb_fertiliser_zone_controller.sv
// Table-driven bench for fertiliser_zone_controller (ZONES=3, DOSE=8, FLUSH=4).
// Each vector is driven on the falling edge and checked 1 time unit after the rising edge.
module tb_fertiliser_zone_controller;

  localparam int ZONES = 3;
  localparam int ZW    = 2;
  localparam int CW    = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             low_level = 1'b0;
  logic             empty_tank = 1'b0;
  logic [ZONES-1:0] splinker = '0;
  logic             fertilise_push = 1'b0;
  logic [ZW-1:0]    zone_select = '0;
  logic             alarm_clear = 1'b0;
  logic             fertilising, cleaning, busy, done, alarm;
  logic [ZONES-1:0] zone_valve;
  logic [1:0]       alarm_code;
  logic [CW-1:0]    dose_remaining;

  fertiliser_zone_controller #(.ZONES(ZONES), .DOSE_CYCLES(8), .FLUSH_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .low_level(low_level), .empty_tank(empty_tank),
    .splinker(splinker), .fertilise_push(fertilise_push), .zone_select(zone_select),
    .alarm_clear(alarm_clear), .fertilising(fertilising), .cleaning(cleaning),
    .zone_valve(zone_valve), .busy(busy), .done(done), .alarm(alarm),
    .alarm_code(alarm_code), .dose_remaining(dose_remaining)
  );

  always #5 clock = ~clock;

  // Output bundle: {fertilising, cleaning, zone_valve, busy, done, alarm, alarm_code, dose_remaining}
  typedef struct {
    logic             low;
    logic             empty;
    logic [ZONES-1:0] spl;
    logic             push;
    logic [ZW-1:0]    zs;
    logic             clr;
    logic [13:0]      exp_out;
  } vec_t;

  vec_t vec_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [13:0] pack_out(input logic f, input logic c, input logic [2:0] v,
                                           input logic b, input logic d, input logic a,
                                           input logic [1:0] code, input int dose);
    logic [3:0] dr;
    dr = 4'(dose);
    return {f, c, v, b, d, a, code, dr};
  endfunction

  function automatic logic [13:0] dut_out();
    return {fertilising, cleaning, zone_valve, busy, done, alarm, alarm_code, dose_remaining};
  endfunction

  task automatic add(input logic low, input logic empty, input logic [2:0] spl, input logic push,
                     input int zs, input logic clr, input logic [13:0] e);
    vec_t v;
    v.low = low; v.empty = empty; v.spl = spl; v.push = push;
    v.zs = 2'(zs); v.clr = clr; v.exp_out = e;
    vec_q.push_back(v);
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (fert,clean,valve,busy,done,alarm,code,dose)", name, got, exp);
    end else begin
      $display("ok   %s: %b", name, got);
    end
  endtask

  logic [13:0] idle0;
  logic [13:0] clean0;

  initial begin
    int fert_cnt;
    int done_cnt;
    idle0 = pack_out(0, 0, 3'b000, 0, 0, 0, 2'd0, 0);

    // A: zone 2, push held 20 cycles -> one 8-cycle dose, 4-cycle flush, single done pulse.
    for (int k = 0; k <= 20; k++) begin
      if (k <= 7)       add(0, 0, 3'b100, k < 20, 2, 0, pack_out(1, 0, 3'b100, 1, 0, 0, 2'd0, 8 - k));
      else if (k <= 11) add(0, 0, 3'b100, 1, 2, 0, pack_out(0, 1, 3'b000, 1, 0, 0, 2'd0, 0));
      else if (k == 12) add(0, 0, 3'b100, 1, 2, 0, pack_out(0, 0, 3'b000, 0, 1, 0, 2'd0, 0));
      else              add(0, 0, 3'b100, k < 20, 2, 0, idle0);
    end
    // B: zone 1, empty tank during dose cycle 3 -> flush next cycle, flush ignores empty_tank, no alarm.
    for (int k = 0; k <= 7; k++) begin
      if (k <= 2)      add(0, 0, 3'b010, k == 0, 1, 0, pack_out(1, 0, 3'b010, 1, 0, 0, 2'd0, 8 - k));
      else if (k <= 6) add(0, k <= 5, 3'b010, 0, 1, 0, pack_out(0, 1, 3'b000, 1, 0, 0, 2'd0, 0));
      else             add(0, 0, 3'b010, 0, 1, 0, pack_out(0, 0, 3'b000, 0, 1, 0, 2'd0, 0));
    end
    // C: zone 0, sprinkler drops exactly when the dose would complete -> abort wins, code 2.
    for (int k = 0; k <= 12; k++) begin
      if (k <= 7)       add(0, 0, 3'b001, k == 0, 0, 0, pack_out(1, 0, 3'b001, 1, 0, 0, 2'd0, 8 - k));
      else if (k <= 11) add(0, 0, 3'b000, 0, 0, 0, pack_out(0, 1, 3'b000, 1, 0, 1, 2'd2, 0));
      else              add(0, 0, 3'b000, 0, 0, 0, pack_out(0, 0, 3'b000, 0, 1, 1, 2'd2, 0));
    end
    // D: refusals, clear, and a bad-zone event coinciding with a clear.
    add(0, 0, 3'b001, 1, 1, 0, pack_out(0, 0, 3'b000, 0, 0, 1, 2'd1, 0));
    add(0, 0, 3'b001, 0, 1, 0, pack_out(0, 0, 3'b000, 0, 0, 1, 2'd1, 0));
    add(0, 0, 3'b001, 0, 1, 1, idle0);
    add(1, 0, 3'b001, 1, 0, 0, pack_out(0, 0, 3'b000, 0, 0, 1, 2'd1, 0));
    add(0, 0, 3'b001, 0, 0, 0, pack_out(0, 0, 3'b000, 0, 0, 1, 2'd1, 0));
    add(0, 0, 3'b001, 1, 3, 1, pack_out(0, 0, 3'b000, 0, 0, 1, 2'd3, 0));
    add(0, 0, 3'b001, 0, 3, 0, pack_out(0, 0, 3'b000, 0, 0, 1, 2'd3, 0));
    // E: push during flush ignored; new dose after done despite active alarm; zone_select change mid-dose ignored.
    for (int k = 0; k <= 16; k++) begin
      if (k <= 7)       add(0, 0, 3'b100, k <= 1, 2, 0, pack_out(1, 0, 3'b100, 1, 0, 1, 2'd3, 8 - k));
      else if (k <= 11) add(0, 0, 3'b100, k == 10, 2, 0, pack_out(0, 1, 3'b000, 1, 0, 1, 2'd3, 0));
      else if (k == 12) add(0, 0, 3'b100, 0, 2, 0, pack_out(0, 0, 3'b000, 0, 1, 1, 2'd3, 0));
      else              add(0, 0, 3'b100, k <= 14, (k >= 14) ? 0 : 2, 0,
                            pack_out(1, 0, 3'b100, 1, 0, 1, 2'd3, 8 - (k - 13)));
    end

    // Reset state.
    #12;
    check("reset_state", dut_out(), idle0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vec_q.size(); i++) begin
      @(negedge clock);
      low_level      = vec_q[i].low;
      empty_tank     = vec_q[i].empty;
      splinker       = vec_q[i].spl;
      fertilise_push = vec_q[i].push;
      zone_select    = vec_q[i].zs;
      alarm_clear    = vec_q[i].clr;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), dut_out(), vec_q[i].exp_out);
    end

    // Asynchronous reset mid-dose at dose_remaining=5: clears state and alarm without a clock edge.
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("async_reset_mid_dose", dut_out(), idle0);
    @(posedge clock);
    #1;
    check("reset_held", dut_out(), idle0);
    @(negedge clock);
    reset          = 1'b0;
    fertilise_push = 1'b0;
    splinker       = 3'b010;
    zone_select    = 2'd1;

    // Held push after reset: bounded watch for exactly one done and 8 dosing cycles.
    @(negedge clock);
    fertilise_push = 1'b1;
    fert_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock);
      #1;
      if (fertilising) fert_cnt++;
      if (done) done_cnt++;
    end
    check("held_push_dose_len", 14'(fert_cnt), 14'd8);
    check("held_push_done_cnt", 14'(done_cnt), 14'd1);
    clean0 = idle0;
    check("held_push_final_idle", dut_out(), clean0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
